// File: rtl/serial_paralelo.sv
// serial_paralelo: receive-side serial-to-parallel stage.
// Finds byte alignment on the idle comma in an MSB-first serial stream.
// Declares the link active after COMMA_COUNT consecutive aligned commas.
// While active, outputs each non-comma byte with a valid flag.
//
// Ports:
//   clk_32f   in   bit-rate clock; all logic runs on its rising edge
//   reset     in   synchronous, active-high reset
//   data_in   in   serial bit stream, MSB of each byte first
//   data_out  out  [7:0] last received data byte
//   valid_out out  high while data_out holds a data (non-comma) byte
//   active    out  high while aligned and in ACTIVE
//
// Optional build macro SP_LOS_TIMEOUT_EN:
//   Drops the link back to SEARCH once LOS_BYTES consecutive data bytes
//   have been received without an intervening comma.
//
// state  | meaning
// SEARCH | sliding bit-by-bit comparison, looking for the first comma
// ALIGN  | byte phase locked, counting consecutive aligned commas
// ACTIVE | link up, data bytes presented on byte boundaries
module serial_paralelo #(
  parameter logic [7:0] COMMA       = 8'hBC,
  parameter int         COMMA_COUNT = 4,
  parameter int         LOS_BYTES   = 64
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       active
);

  if (COMMA_COUNT < 1 || COMMA_COUNT > 15) begin : g_bad_comma_count
    $error("serial_paralelo: COMMA_COUNT must be 1..15");
  end
  if (LOS_BYTES < 1 || LOS_BYTES > 255) begin : g_bad_los_bytes
    $error("serial_paralelo: LOS_BYTES must be 1..255");
  end

  typedef enum logic [1:0] {SEARCH, ALIGN, ACTIVE} state_t;

  localparam logic [3:0] COMMA_TGT = 4'(COMMA_COUNT);

  state_t     state, state_nxt;
  logic [6:0] sreg;
  logic [7:0] cand;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic [3:0] comma_cnt, comma_cnt_nxt;
  logic [7:0] data_nxt;
  logic       valid_nxt, active_nxt;
  logic       is_comma, boundary, los_hit;

  // Candidate byte includes the bit being sampled on this edge.
  assign cand     = {sreg, data_in};
  assign is_comma = (cand == COMMA);
  assign boundary = (bit_cnt == 3'd7);

`ifdef SP_LOS_TIMEOUT_EN
  localparam logic [7:0] LOS_TGT = 8'(LOS_BYTES);

  logic [7:0] run_cnt, run_nxt;

  // The run count reaches LOS_TGT on the boundary that outputs the last
  // tolerated byte; the exit happens on the edge after that.
  assign los_hit = (state == ACTIVE) && (run_cnt == LOS_TGT);

  always_comb begin
    run_nxt = run_cnt;
    if (state == ACTIVE) begin
      if (los_hit)
        run_nxt = 8'd0;
      else if (boundary)
        run_nxt = is_comma ? 8'd0 : run_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) run_cnt <= 8'd0;
    else       run_cnt <= run_nxt;
  end
`else
  assign los_hit = 1'b0;
`endif

  // State and output registers.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state     <= SEARCH;
      sreg      <= 7'd0;
      bit_cnt   <= 3'd0;
      comma_cnt <= 4'd0;
      data_out  <= 8'h00;
      valid_out <= 1'b0;
      active    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sreg      <= cand[6:0];
      bit_cnt   <= bit_cnt_nxt;
      comma_cnt <= comma_cnt_nxt;
      data_out  <= data_nxt;
      valid_out <= valid_nxt;
      active    <= active_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt + 3'd1;
    comma_cnt_nxt = comma_cnt;
    case (state)
      SEARCH: begin
        if (is_comma) begin
          // This edge becomes the byte boundary reference.
          bit_cnt_nxt   = 3'd0;
          comma_cnt_nxt = 4'd1;
          state_nxt     = (COMMA_TGT == 4'd1) ? ACTIVE : ALIGN;
        end
      end
      ALIGN: begin
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_nxt = comma_cnt + 4'd1;
            if ((comma_cnt + 4'd1) == COMMA_TGT)
              state_nxt = ACTIVE;
          end else begin
            comma_cnt_nxt = 4'd0;
            state_nxt     = SEARCH;
          end
        end
      end
      ACTIVE: begin
        if (los_hit) begin
          comma_cnt_nxt = 4'd0;
          state_nxt     = SEARCH;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  // Output logic; results are registered so active tracks the state change.
  always_comb begin
    data_nxt   = data_out;
    valid_nxt  = valid_out;
    active_nxt = (state_nxt == ACTIVE);
    if (state == ACTIVE) begin
      if (los_hit) begin
        valid_nxt = 1'b0;
      end else if (boundary) begin
        if (is_comma) begin
          valid_nxt = 1'b0;
        end else begin
          data_nxt  = cand;
          valid_nxt = 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: two instances (COMMA_COUNT 4 and 1) share one
// serial stream; a byte-level model predicts outputs every cycle, and
// directed literal checks pin the model at the interesting moments.
module tb_serial_paralelo;

  localparam int LOS = 3;
  localparam int BC  = 188;
`ifdef SP_LOS_TIMEOUT_EN
  localparam bit LOS_EN = 1'b1;
`else
  localparam bit LOS_EN = 1'b0;
`endif

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] d0, d1;
  logic       v0, v1, a0, a1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_32f = ~clk_32f;

  serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(4), .LOS_BYTES(LOS)) dut (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(d0), .valid_out(v0), .active(a0));

  serial_paralelo #(.COMMA(8'hBC), .COMMA_COUNT(1), .LOS_BYTES(LOS)) dut1 (
    .clk_32f(clk_32f), .reset(reset), .data_in(data_in),
    .data_out(d1), .valid_out(v1), .active(a1));

  // Model: mode 0 hunting, 1 counting commas, 2 link up.
  int cc[2] = '{4, 1};
  int m_mode[2], m_n[2], m_cnt[2], m_run[2], m_hist[2];
  int m_data[2], m_valid[2], m_act[2];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input int k, input bit rst, input bit din);
    int cand;
    if (rst) begin
      m_mode[k] = 0; m_n[k] = 0; m_cnt[k] = 0; m_run[k] = 0; m_hist[k] = 0;
      m_data[k] = 0; m_valid[k] = 0; m_act[k] = 0;
      return;
    end
    cand      = (m_hist[k] * 2 + int'(din)) % 256;
    m_hist[k] = cand;
    if (m_mode[k] == 0) begin
      if (cand == BC) begin
        m_n[k]   = 0;
        m_cnt[k] = 1;
        if (m_cnt[k] >= cc[k]) begin m_mode[k] = 2; m_act[k] = 1; end
        else m_mode[k] = 1;
      end
    end else if (LOS_EN && m_mode[k] == 2 && m_run[k] == LOS) begin
      m_mode[k] = 0; m_act[k] = 0; m_valid[k] = 0; m_cnt[k] = 0; m_run[k] = 0;
    end else begin
      m_n[k]++;
      if (m_n[k] == 8) begin
        m_n[k] = 0;
        if (m_mode[k] == 1) begin
          if (cand == BC) begin
            m_cnt[k]++;
            if (m_cnt[k] == cc[k]) begin m_mode[k] = 2; m_act[k] = 1; end
          end else begin
            m_cnt[k] = 0; m_mode[k] = 0;
          end
        end else begin
          if (cand != BC) begin
            m_data[k] = cand; m_valid[k] = 1; m_run[k]++;
          end else begin
            m_valid[k] = 0; m_run[k] = 0;
          end
        end
      end
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    bit r, b;
    forever begin
      @(posedge clk_32f);
      r = reset;
      b = data_in;
      #1;
      for (int k = 0; k < 2; k++) model_step(k, r, b);
      check("m0_data",   int'(d0), m_data[0]);
      check("m0_valid",  int'(v0), m_valid[0]);
      check("m0_active", int'(a0), m_act[0]);
      check("m1_data",   int'(d1), m_data[1]);
      check("m1_valid",  int'(v1), m_valid[1]);
      check("m1_active", int'(a1), m_act[1]);
    end
  end

  task automatic send_bit(input bit b);
    @(negedge clk_32f);
    reset   = 1'b0;
    data_in = b;
    @(posedge clk_32f);
    #2;
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = 7; i > 7 - n; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic do_reset();
    @(negedge clk_32f);
    reset   = 1'b1;
    data_in = 1'b0;
    @(posedge clk_32f);
    #2;
  endtask

  initial begin
    do_reset();
    check("rst_data",   int'(d0), 0);
    check("rst_valid",  int'(v0), 0);
    check("rst_active", int'(a0), 0);

    // 1: offset bits, then commas; active on the 4th comma's last bit.
    send_bit(1); send_bit(0); send_bit(1);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    send_bits(8'hBC, 7);
    check("t1_act_before", int'(a0), 0);
    send_bit(0);
    check("t1_act_rise", int'(a0), 1);
    check("t1_valid",    int'(v0), 0);
    send_byte(8'hBC);
    check("t1_data",  int'(d0), 0);
    check("t1_cc1_act", int'(a1), 1);

    // 2: data bytes held 8 cycles, comma drops valid but keeps data.
    send_byte(8'h5A);
    check("t2_5a_data",  int'(d0), 'h5A);
    check("t2_5a_valid", int'(v0), 1);
    send_bits(8'hC3, 7);
    check("t2_5a_hold", int'(d0), 'h5A);
    send_bit(1);
    check("t2_c3_data", int'(d0), 'hC3);
    send_byte(8'hBC);
    check("t2_bc_valid", int'(v0), 0);
    check("t2_bc_data",  int'(d0), 'hC3);

    // 3: non-comma during alignment restarts the search.
    do_reset();
    send_bit(0); send_bit(1); send_bit(0);
    send_byte(8'hBC); send_byte(8'hBC); send_byte(8'h11);
    check("t3_after_11", int'(a0), 0);
    for (int i = 0; i < 3; i++) send_byte(8'hBC);
    check("t3_three_commas", int'(a0), 0);
    send_byte(8'hBC);
    check("t3_fourth_comma", int'(a0), 1);

    // 4: COMMA_COUNT=1 goes active on the first comma.
    do_reset();
    send_byte(8'hBC);
    check("t4_cc1_act", int'(a1), 1);
    check("t4_cc4_act", int'(a0), 0);
    send_byte(8'h77);
    check("t4_data",  int'(d1), 'h77);
    check("t4_valid", int'(v1), 1);

    // 5: reset mid-byte while active, then reacquire.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'hA5);
    check("t5_data", int'(d0), 'hA5);
    send_byte(8'hA5);
    send_bits(8'hA5, 3);
    do_reset();
    check("t5_rst_data",  int'(d0), 0);
    check("t5_rst_valid", int'(v0), 0);
    check("t5_rst_act",   int'(a0), 0);
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    check("t5_reacq", int'(a0), 1);

`ifdef SP_LOS_TIMEOUT_EN
    // 6: run of LOS data bytes drops the link one edge after the last.
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h01); send_byte(8'h02);
    check("t6_still_act", int'(a0), 1);
    send_byte(8'h03);
    check("t6_03_data",  int'(d0), 'h03);
    check("t6_03_valid", int'(v0), 1);
    check("t6_03_act",   int'(a0), 1);
    send_bit(0);
    check("t6_drop_act",   int'(a0), 0);
    check("t6_drop_valid", int'(v0), 0);
    do_reset();
    for (int i = 0; i < 4; i++) send_byte(8'hBC);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'hBC); send_byte(8'h03);
    check("t6b_data", int'(d0), 'h03);
    send_bit(0);
    check("t6b_act", int'(a0), 1);
`endif

    send_bits(8'h00, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
